// File: rtl/bsg_mux_one_hot_pipe.sv
// rtl/bsg_mux_one_hot_pipe.sv - one-hot AND-OR mux feeding a 2-entry valid/ready buffer with malformed-select counting
// Optional build macro BSG_MUX_ONE_HOT_PIPE_PRIORITY_EN: multi-hot select resolves to the lowest set index.

module bsg_mux_one_hot_pipe #(
  parameter int width_p     = 16,
  parameter int els_p       = 4,
  parameter int err_cnt_w_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  output logic                     ready_and_o,
  input  logic [els_p*width_p-1:0] data_i,
  input  logic [els_p-1:0]         sel_one_hot_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     ready_and_i,
  output logic                     err_o,
  output logic [err_cnt_w_p-1:0]   err_cnt_o,
  input  logic                     clear_err_i
);

  logic [width_p-1:0]     w_mux_data;
  logic                   w_malformed;
  logic                   w_enq;
  logic                   w_deq;
  logic                   w_cnt_sat;

  logic [width_p-1:0]     r_mem [2];
  logic [width_p-1:0]     r_last;
  logic                   r_rd_ptr;
  logic                   r_wr_ptr;
  logic [1:0]             r_count;
  logic                   r_err;
  logic [err_cnt_w_p-1:0] r_err_cnt;

`ifdef BSG_MUX_ONE_HOT_PIPE_PRIORITY_EN
  // Walk from the top down so the lowest set index is the one that sticks.
  always_comb begin
    w_mux_data = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (sel_one_hot_i[k]) w_mux_data = data_i[k*width_p +: width_p];
    end
  end
`else
  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < els_p; k++) begin
      w_mux_data = w_mux_data | (data_i[k*width_p +: width_p] & {width_p{sel_one_hot_i[k]}});
    end
  end
`endif

  assign w_malformed = ($countones(sel_one_hot_i) != 1);
  assign ready_and_o = (r_count != 2'd2);
  assign v_o         = (r_count != 2'd0);
  assign w_enq       = v_i & ready_and_o;
  assign w_deq       = v_o & ready_and_i;
  assign w_cnt_sat   = &r_err_cnt;

  // When empty, present the most recently dequeued word rather than a stale slot.
  assign data_o      = (r_count == 2'd0) ? r_last : r_mem[r_rd_ptr];
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_last   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_mem[r_wr_ptr] <= w_mux_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_deq) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A malformed accept in the same cycle as a clear counts as the first new event.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_enq && w_malformed) begin
      r_err <= 1'b1;
      if (clear_err_i)    r_err_cnt <= err_cnt_w_p'(1);
      else if (!w_cnt_sat) r_err_cnt <= r_err_cnt + err_cnt_w_p'(1);
    end else if (clear_err_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end
  end

endmodule
